// File: rtl/timer_counter_array.sv
// rtl/timer_counter_array.sv - memory-mapped multi-channel prescaled timer with compare and sticky irq
module timer_counter_array #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sel_i,
  input  logic              we_i,
  input  logic [5:0]        addr_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic [NUM_CH-1:0] irq_o
);

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_PRESC = 2'd1;
  localparam logic [1:0] REG_CMP   = 2'd2;
  localparam logic [1:0] REG_CNT   = 2'd3;

  logic        wr_en;
  logic [1:0]  reg_sel;
  logic [31:0] rd_val [NUM_CH];
  logic        unused_addr;

  assign wr_en       = sel_i & we_i;
  assign reg_sel     = addr_i[3:2];
  assign unused_addr = ^addr_i[1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic               en, mode, ie, iflag;
    logic [PRESC_W-1:0] presc, p;
    logic [CNT_W-1:0]   cmp, cnt;
    logic               wr_ch, wr_ctrl, wr_presc, wr_cmp, wr_cnt;
    logic               tick, match;

    assign wr_ch    = wr_en && (addr_i[5:4] == 2'(c));
    assign wr_ctrl  = wr_ch && (reg_sel == REG_CTRL);
    assign wr_presc = wr_ch && (reg_sel == REG_PRESC);
    assign wr_cmp   = wr_ch && (reg_sel == REG_CMP);
    assign wr_cnt   = wr_ch && (reg_sel == REG_CNT);

    assign tick  = en && (p == presc);
    // A CNT write suppresses the compare on the same edge.
    assign match = tick && (cnt == cmp) && !wr_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        en    <= 1'b0;
        mode  <= 1'b0;
        ie    <= 1'b0;
        iflag <= 1'b0;
        presc <= '0;
        cmp   <= '1;
        cnt   <= '0;
        p     <= '0;
      end else begin
        if (wr_presc || wr_cnt || (wr_ctrl && data_i[0] && !en)) p <= '0;
        else if (tick)                                           p <= '0;
        else if (en)                                             p <= p + 1'b1;

        if (wr_cnt)    cnt <= data_i[CNT_W-1:0];
        else if (tick) cnt <= (cnt == cmp) ? '0 : cnt + 1'b1;

        if (wr_presc) presc <= data_i[PRESC_W-1:0];
        if (wr_cmp)   cmp   <= data_i[CNT_W-1:0];

        // Software EN write beats the one-shot auto-disable.
        if (wr_ctrl) begin
          en   <= data_i[0];
          mode <= data_i[1];
          ie   <= data_i[2];
        end else if (match && mode) begin
          en <= 1'b0;
        end

        // Hardware set beats software clear so no event is lost.
        if (match)                       iflag <= 1'b1;
        else if (wr_ctrl && data_i[3])   iflag <= 1'b0;
      end
    end

    assign irq_o[c] = iflag & ie;

    assign rd_val[c] = (reg_sel == REG_CTRL)  ? {28'd0, iflag, ie, mode, en} :
                       (reg_sel == REG_PRESC) ? 32'(presc) :
                       (reg_sel == REG_CMP)   ? 32'(cmp)   :
                                                32'(cnt);
  end

  always_comb begin
    data_o = '0;
    if (sel_i && !we_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (addr_i[5:4] == 2'(c)) data_o = rd_val[c];
      end
    end
  end

endmodule
